spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: one DATA_WIDTH-bit full-duplex transfer per start request, CPOL/CPHA and SCK rate set by parameters.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift bit 0 first (default build shifts MSB first).
module spi_master #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 2,
   parameter bit          CPOL       = 1'b0,
   parameter bit          CPHA       = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  nss_o,
   output logic                  sck_o,
   output logic                  sdo_o,
   input  logic                  sdi_i
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EW = $clog2(2 * DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [EW-1:0]         ecnt;
   logic [DATA_WIDTH-1:0] tx;
   logic [DATA_WIDTH-1:0] rx;
   logic                  cnt_done;
   logic                  sck_edge;
   logic                  leading;

   assign cnt_done = (cnt == CNT_LAST);
   assign sck_edge = cnt_done && ((state == LEAD) || (state == SHIFT));
   assign leading  = ~ecnt[0];

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
      return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
      return LSB_FIRST ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
      return LSB_FIRST ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         ecnt   <= '0;
         tx     <= '0;
         rx     <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         data_o <= '0;
         nss_o  <= 1'b1;
         sck_o  <= CPOL;
         sdo_o  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (state != IDLE)
            cnt <= cnt_done ? '0 : cnt + CW'(1);

         // Each SCK edge: even edge index is the leading edge, odd the trailing one
         if (sck_edge) begin
            sck_o <= CPOL ^ leading;
            ecnt  <= ecnt + EW'(1);
            if (leading == !CPHA) begin
               rx <= shift_in(rx, sdi_i);
            end else if (CPHA || (ecnt != EDGE_LAST)) begin
               sdo_o <= first_bit(tx);
               tx    <= shift_out(tx);
            end
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= LEAD;
                  busy_o <= 1'b1;
                  nss_o  <= 1'b0;
                  cnt    <= '0;
                  ecnt   <= '0;
                  rx     <= '0;
                  tx     <= CPHA ? data_i : shift_out(data_i);
                  if (!CPHA)
                     sdo_o <= first_bit(data_i);
               end
            end
            LEAD: begin
               if (cnt_done)
                  state <= SHIFT;
            end
            SHIFT: begin
               if (cnt_done && (ecnt == EDGE_LAST))
                  state <= TRAIL;
            end
            TRAIL: begin
               if (cnt_done) begin
                  state  <= GAP;
                  nss_o  <= 1'b1;
                  done_o <= 1'b1;
                  data_o <= rx;
               end
            end
            GAP: begin
               if (cnt_done) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: three parameter sets (loopback default, mode-3 slave model, 16-bit fast loopback).
module tb_spi_master;

`ifdef SPI_MASTER_LSB_FIRST_EN
   localparam bit LSBF = 1'b1;
`else
   localparam bit LSBF = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       start0, busy0, done0, nss0, sck0, sdo0;
   logic [7:0] din0, dout0;
   logic       start1, busy1, done1, nss1, sck1, sdo1;
   logic       miso1 = 1'b0;
   logic [7:0] din1, dout1;
   logic        start2, busy2, done2, nss2, sck2, sdo2;
   logic [15:0] din2, dout2;

   spi_master u0 (
      .clk_i(clk), .rst_i(rst), .start_i(start0), .data_i(din0), .busy_o(busy0), .done_o(done0),
      .data_o(dout0), .nss_o(nss0), .sck_o(sck0), .sdo_o(sdo0), .sdi_i(sdo0));

   spi_master #(.DATA_WIDTH(8), .CLK_DIV(3), .CPOL(1'b1), .CPHA(1'b1)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .data_i(din1), .busy_o(busy1), .done_o(done1),
      .data_o(dout1), .nss_o(nss1), .sck_o(sck1), .sdo_o(sdo1), .sdi_i(miso1));

   spi_master #(.DATA_WIDTH(16), .CLK_DIV(1)) u2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .data_i(din2), .busy_o(busy2), .done_o(done2),
      .data_o(dout2), .nss_o(nss2), .sck_o(sck2), .sdo_o(sdo2), .sdi_i(sdo2));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Mode-3 slave: drives MISO on falling SCK, samples MOSI on rising SCK
   logic [7:0] slv_word = 8'hE1;
   logic [7:0] s_rx = 8'h00;
   int         s_idx = 0;
   always @(negedge sck1 or posedge nss1) begin
      if (nss1) s_idx = 0;
      else begin
         miso1 = slv_word[LSBF ? s_idx : 7 - s_idx];
         s_idx++;
      end
   end
   always @(posedge sck1)
      if (nss1 === 1'b0) s_rx = LSBF ? {sdo1, s_rx[7:1]} : {s_rx[6:0], sdo1};

   // SCK must sit at its idle level whenever the slave is deselected
   bit mon_en = 1'b0;
   int idle_viol = 0;
   always @(negedge clk)
      if (mon_en) begin
         if (nss0 && sck0 !== 1'b0) idle_viol++;
         if (nss1 && sck1 !== 1'b1) idle_viol++;
         if (nss2 && sck2 !== 1'b0) idle_viol++;
      end

   int   edges, edge_bad, ndone, done_cyc;
   logic prev;
`ifdef SPI_MASTER_LSB_FIRST_EN
   int   ones;
`endif

   initial begin
      rst = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      din0 = '0; din1 = '0; din2 = '0;
      repeat (3) step();
      check("rst_nss0", 32'(nss0), 1);
      check("rst_sck0", 32'(sck0), 0);
      check("rst_sdo0", 32'(sdo0), 0);
      check("rst_busy0", 32'(busy0), 0);
      check("rst_done0", 32'(done0), 0);
      check("rst_dout0", 32'(dout0), 0);
      check("rst_sck1", 32'(sck1), 1);
      check("rst_nss2", 32'(nss2), 1);
      rst = 1'b0;
      mon_en = 1'b1;

      // Loopback, defaults, 0x99
      din0 = 8'h99; start0 = 1'b1;
      edges = 0; edge_bad = 0; ndone = 0; done_cyc = -1; prev = sck0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 1) start0 = 1'b0;
         if (sck0 !== prev) begin
            edges++;
            if (n != 1 + 2 * edges) edge_bad++;
         end
         prev = sck0;
         if (done0) begin ndone++; done_cyc = n; end
         if (n == 1) begin
            check("t1_nss_low", 32'(nss0), 0);
            check("t1_busy", 32'(busy0), 1);
            check("t1_first_bit", 32'(sdo0), 1);
         end
         if (n == 5)  check("t1_second_bit", 32'(sdo0), 0);
         if (n == 34) check("t1_dout_stable", 32'(dout0), 0);
         if (n == 35) check("t1_dout", 32'(dout0), 32'h99);
         if (n == 36) check("t1_busy_gap", 32'(busy0), 1);
         if (n == 37) check("t1_busy_drop", 32'(busy0), 0);
      end
      check("t1_edges", 32'(edges), 16);
      check("t1_edge_timing", 32'(edge_bad), 0);
      check("t1_ndone", 32'(ndone), 1);
      check("t1_done_cyc", 32'(done_cyc), 35);

      // Mode 3, CLK_DIV=3, slave returns 0xE1
      din1 = 8'h3C; start1 = 1'b1;
      ndone = 0; done_cyc = -1;
      for (int n = 1; n <= 60; n++) begin
         step();
         if (n == 1) begin
            start1 = 1'b0;
            check("t2_nss_low", 32'(nss1), 0);
            check("t2_sck_lead", 32'(sck1), 1);
         end
         if (done1) begin ndone++; done_cyc = n; end
         if (n == 52) check("t2_dout", 32'(dout1), 32'hE1);
         if (n == 55) check("t2_busy_drop", 32'(busy1), 0);
      end
      check("t2_done_cyc", 32'(done_cyc), 52);
      check("t2_ndone", 32'(ndone), 1);
      check("t2_slave_rx", 32'(s_rx), 32'h3C);
      check("t2_idle_sck", 32'(sck1), 1);
      check("t2_idle_nss", 32'(nss1), 1);

      // start held high: one transfer, then back-to-back restart
      din0 = 8'hFF; start0 = 1'b1;
      ndone = 0; done_cyc = -1;
      for (int n = 1; n <= 80; n++) begin
         step();
         if (done0) begin ndone++; done_cyc = n; end
         if (n == 36) check("t3_ndone_first", 32'(ndone), 1);
         if (n == 37) check("t3_busy_drop", 32'(busy0), 0);
         if (n == 38) begin
            check("t3_restart_busy", 32'(busy0), 1);
            check("t3_restart_nss", 32'(nss0), 0);
            start0 = 1'b0;
         end
      end
      check("t3_ndone", 32'(ndone), 2);
      check("t3_done_cyc", 32'(done_cyc), 72);
      check("t3_dout", 32'(dout0), 32'hFF);

      // CLK_DIV=1, 16-bit loopback
      din2 = 16'hA55A; start2 = 1'b1;
      ndone = 0; done_cyc = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 1) start2 = 1'b0;
         if (done2) begin ndone++; done_cyc = n; end
         if (n == 34) check("t5_busy_gap", 32'(busy2), 1);
         if (n == 35) check("t5_busy_drop", 32'(busy2), 0);
      end
      check("t5_done_cyc", 32'(done_cyc), 34);
      check("t5_ndone", 32'(ndone), 1);
      check("t5_dout", 32'(dout2), 32'hA55A);

`ifdef SPI_MASTER_LSB_FIRST_EN
      // LSB first: only the first bit period carries the 1
      din0 = 8'h01; start0 = 1'b1;
      ones = 0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 1) start0 = 1'b0;
         if (n <= 34 && sdo0 === 1'b1) ones++;
         if (n == 35) check("t6_dout", 32'(dout0), 1);
      end
      check("t6_sdo_ones", 32'(ones), 4);
`endif

      // Reset after the 5th SCK edge aborts without done
      din0 = 8'hA5; start0 = 1'b1;
      edges = 0; prev = sck0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 1) start0 = 1'b0;
         if (sck0 !== prev) edges++;
         prev = sck0;
         if (edges == 5) break;
      end
      check("t4_edges_seen", 32'(edges), 5);
      rst = 1'b1;
      step();
      check("t4_nss", 32'(nss0), 1);
      check("t4_sck", 32'(sck0), 0);
      check("t4_busy", 32'(busy0), 0);
      check("t4_done", 32'(done0), 0);
      check("t4_dout", 32'(dout0), 0);
      rst = 1'b0;
      ndone = 0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (done0) ndone++;
      end
      check("t4_no_done", 32'(ndone), 0);
      check("t4_busy_after", 32'(busy0), 0);

      check("sck_idle_when_nss_high", 32'(idle_viol), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
